carry_add_pipe: RTL and testbench

Pipelined WIDTH-bit adder/subtractor built from 4-bit carry-chain segments. It computes one CARRY4-equivalent segment per pipeline stage and registers the carry between stages. It sits directly downstream of the CARRY4 primitive model in our Verilator-compatible Xilinx primitive set. Its purpose is to give wide arithmetic a fixed per-stage carry depth of 4 bits, at the cost of WIDTH/4 cycles of latency.

---
 rtl/carry_add_pipe.sv | 84 ++++++++
 tb/tb_carry_add_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/carry_add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one 4-bit carry-chain segment per stage,
// with input skew, registered inter-stage carry and output deskew.
module carry_add_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             VALID_I,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             VALID_O,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             OV
);

  localparam int NSEG = WIDTH / 4;

  // r_v[0]/r_c[0] belong to the operand capture stage; index k+1 follows segment k.
  logic [NSEG:0]      r_v;
  logic [NSEG:0]      r_c;
  logic [WIDTH-1:0]   r_a [0:NSEG-1];
  logic [WIDTH-1:0]   r_b [0:NSEG-1];
  logic [WIDTH-1:0]   r_s [0:NSEG-1];
  logic               r_ov;

  logic [WIDTH-1:0]   w_sum_nxt [0:NSEG-1];
  logic [NSEG-1:0]    w_cout;
  logic               w_cmsb;

  // Each segment is a CARRY4 equivalent: mux-chain carry with DI = A.
  always_comb begin
    logic w_c;
    logic w_s;
    w_cout = '0;
    w_cmsb = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      w_sum_nxt[k] = r_s[(k == 0) ? 0 : k - 1];
      if (k == 0) w_sum_nxt[k] = '0;
      w_c = r_c[k];
      for (int i = 0; i < 4; i++) begin
        w_s = r_a[k][4*k+i] ^ r_b[k][4*k+i];
        if (k == NSEG - 1 && i == 3) w_cmsb = w_c;
        w_sum_nxt[k][4*k+i] = w_s ^ w_c;
        w_c = w_s ? w_c : r_a[k][4*k+i];
      end
      w_cout[k] = w_c;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_v  <= '0;
      r_c  <= '0;
      r_ov <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else if (CE) begin
      r_v    <= {r_v[NSEG-1:0], VALID_I};
      r_c    <= {w_cout, SUB};
      r_a[0] <= A;
      r_b[0] <= B ^ {WIDTH{SUB}};
      for (int k = 1; k < NSEG; k++) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
      for (int k = 0; k < NSEG; k++) begin
        r_s[k] <= w_sum_nxt[k];
      end
      r_ov <= w_cout[NSEG-1] ^ w_cmsb;
    end
  end

  assign VALID_O = r_v[NSEG];
  assign SUM     = r_s[NSEG-1];
  assign CO      = r_c[NSEG];
  assign OV      = r_ov;

endmodule

// File: tb/tb_carry_add_pipe.sv
// Scoreboard bench for carry_add_pipe: arithmetic reference model, random stream
// with bubbles and CE stalls, mid-flight reset, plus a WIDTH=4 instance.
module tb_carry_add_pipe;

  localparam int W    = 16;
  localparam int NSEG = W / 4;

  logic         clk = 1'b0;
  logic         rst_n, ce, v_i, sub;
  logic [W-1:0] a, b;
  logic         v_o, co, ov;
  logic [W-1:0] sum;

  logic         v4, v_o4, co4, ov4;
  logic [3:0]   a4, b4, sum4;
  logic         p_v4 = 1'b0;
  logic [3:0]   p_a4 = '0, p_b4 = '0;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    int           due;
  } exp_t;

  exp_t q[$];
  exp_t e, hold;
  logic hold_v = 1'b0;
  int   en_edges = 0;
  int   checks = 0;
  int   failures = 0;

  carry_add_pipe #(.WIDTH(W)) u_dut (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .VALID_I(v_i), .SUB(sub),
    .A(a), .B(b), .VALID_O(v_o), .SUM(sum), .CO(co), .OV(ov)
  );

  carry_add_pipe #(.WIDTH(4)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .CE(ce), .VALID_I(v4), .SUB(1'b0),
    .A(a4), .B(b4), .VALID_O(v_o4), .SUM(sum4), .CO(co4), .OV(ov4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain two's-complement arithmetic on wide integers.
  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         m;
    logic [W:0]   r;
    r = {1'b0, x} + (s ? {1'b0, ~y} : {1'b0, y}) + {{W{1'b0}}, s};
    m.sum = r[W-1:0];
    m.co  = r[W];
    if (s) m.ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   m.ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    m.due = 0;
    return m;
  endfunction

  task automatic issue(input logic c, input logic v, input logic s,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    @(negedge clk);
    ce = c; v_i = v; sub = s; a = x; b = y;
    v4 = p_v4; a4 = p_a4; b4 = p_b4;
    @(posedge clk);
    if (c) begin
      en_edges++;
      if (v) begin
        m = model(s, x, y);
        m.due = en_edges + NSEG;
        q.push_back(m);
      end
    end
  endtask

  // Monitor: compares outputs after every edge, independent of the driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (ce) begin
          while (q.size() > 0 && q[0].due < en_edges) begin
            checks++;
            failures++;
            $display("FAIL missing_result: got no output expected sum %h at edge %0d", q[0].sum, q[0].due);
            void'(q.pop_front());
          end
          if (v_o) begin
            if (q.size() == 0 || q[0].due != en_edges) begin
              checks++;
              failures++;
              $display("FAIL unexpected_valid: got sum %h at edge %0d expected no result", sum, en_edges);
              hold_v = 1'b0;
            end else begin
              e = q.pop_front();
              chk("sum", 32'(sum), 32'(e.sum));
              chk("co", 32'(co), 32'(e.co));
              chk("ov", 32'(ov), 32'(e.ov));
              hold   = e;
              hold_v = 1'b1;
            end
          end else begin
            hold_v = 1'b0;
          end
        end else if (hold_v) begin
          chk("hold_valid", 32'(v_o), 32'd1);
          chk("hold_sum", 32'(sum), 32'(hold.sum));
          chk("hold_co", 32'(co), 32'(hold.co));
          chk("hold_ov", 32'(ov), 32'(hold.ov));
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; ce = 1'b0; v_i = 1'b0; sub = 1'b0; a = '0; b = '0;
    v4 = 1'b0; a4 = '0; b4 = '0;
    #1;
    chk("rst_valid", 32'(v_o), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_valid4", 32'(v_o4), 32'd0);
    chk("rst_sum4", 32'(sum4), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0001);
    issue(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0001);
    issue(1'b1, 1'b1, 1'b0, 16'h7FFF, 16'h0001);
    issue(1'b1, 1'b1, 1'b1, 16'h8000, 16'h0001);
    issue(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001);
    repeat (6) issue(1'b1, 1'b0, 1'b0, '0, '0);

    n = 0;
    while (n < 100) begin
      logic c, v;
      c = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 4) != 0);
      if (c && v) n++;
      issue(c, v, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
      if ($urandom_range(0, 9) == 0)
        repeat ($urandom_range(2, 6))
          issue(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    end
    repeat (8) issue(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset with three operations in flight, the first already on the outputs.
    issue(1'b1, 1'b1, 1'b0, 16'h4321, 16'h1000);
    issue(1'b1, 1'b1, 1'b1, 16'h5555, 16'h0123);
    issue(1'b1, 1'b1, 1'b0, 16'h0F0F, 16'h0101);
    issue(1'b1, 1'b0, 1'b0, '0, '0);
    issue(1'b1, 1'b0, 1'b0, '0, '0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(v_o), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_co", 32'(co), 32'd0);
    chk("midrst_ov", 32'(ov), 32'd0);
    q.delete();
    hold_v = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) issue(1'b1, 1'b0, 1'b0, '0, '0);
    issue(1'b1, 1'b1, 1'b0, 16'h1234, 16'h1111);
    repeat (6) issue(1'b1, 1'b0, 1'b0, '0, '0);
    chk("after_reset_queue", 32'(q.size()), 32'd0);

    // WIDTH=4 instance: one-cycle latency.
    p_v4 = 1'b1; p_a4 = 4'hF; p_b4 = 4'h1;
    issue(1'b1, 1'b0, 1'b0, '0, '0);
    p_v4 = 1'b0; p_a4 = 4'h0; p_b4 = 4'h0;
    #1;
    chk("w4_early_valid", 32'(v_o4), 32'd0);
    issue(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("w4_valid", 32'(v_o4), 32'd1);
    chk("w4_sum", 32'(sum4), 32'h0);
    chk("w4_co", 32'(co4), 32'd1);
    chk("w4_ov", 32'(ov4), 32'd0);
    issue(1'b1, 1'b0, 1'b0, '0, '0);
    #1;
    chk("w4_bubble", 32'(v_o4), 32'd0);

    repeat (4) issue(1'b1, 1'b0, 1'b0, '0, '0);
    chk("drain_queue", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
